// File: rtl/prio_pkg.sv
// Shared constants and helpers for the registered priority encoder.
package prio_pkg;

    // Priority scheme selectors for the MODE parameter
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Widest request vector the onehot helper supports
    localparam int MAX_N = 64;

    // One-hot decode of an index; callers cast the result down to their own width
    function automatic logic [MAX_N-1:0] onehot(input logic [31:0] idx);
        return MAX_N'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational find-first-set searching downward from a start position,
// wrapping from bit 0 back to bit N-1.
module prio_find #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Two copies side by side let a plain downward scan cover the wrap-around
    logic [2*N-1:0] dbl;
    logic [W:0]     pos;
    localparam logic [W:0] N_W1 = (W+1)'(N);

    assign dbl = {vec, vec};

    // Scan positions start+N down to start+1 in the doubled vector; first hit wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start} + (W+1)'(N - i);
            if (!found && dbl[pos]) begin
                found = 1'b1;
                idx   = (pos >= N_W1) ? W'(pos - N_W1) : pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-request priority encoder with pending latch, selection mask
// and a valid/ready output; fixed or round-robin priority.
module prio_encoder_rr
    import prio_pkg::*;
#(
    parameter int N    = 8,
    parameter int MODE = MODE_FIXED,
    parameter int EDGE = 1,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending_o
);

    logic [N-1:0] req_q;
    logic [N-1:0] pending;
    logic [N-1:0] set_vec;
    logic [N-1:0] clr_vec;
    logic [N-1:0] pend_kept;
    logic [N-1:0] cand_next;
    logic         transfer;
    logic [W-1:0] rr_ptr;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] start;
    logic         found;
    logic [W-1:0] sel_idx;

    assign pending_o = pending;

    // Capture, clear and next-candidate computation, plus the search start point
    always_comb begin
        set_vec   = (EDGE != 0) ? (req_i & ~req_q) : req_i;
        transfer  = out_valid && out_ready;
        clr_vec   = transfer ? N'(onehot(32'(out_idx))) : '0;
        pend_kept = pending & ~clr_vec;
        cand_next = pend_kept & mask_i;
        ptr_eff   = transfer ? out_idx : rr_ptr;
        if (MODE == MODE_RR) begin
            start = (ptr_eff == '0) ? W'(N - 1) : ptr_eff - W'(1);
        end else begin
            start = W'(N - 1);
        end
    end

    prio_find #(
        .N (N),
        .W (W)
    ) u_find (
        .vec   (cand_next),
        .start (start),
        .found (found),
        .idx   (sel_idx)
    );

    // State update: pending latch, output register (held while stalled) and rr pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            rr_ptr    <= '0;
        end else begin
            req_q   <= req_i;
            pending <= pend_kept | set_vec;
            if (!out_valid || out_ready) begin
                out_valid <= found;
                if (found) begin
                    out_idx <= sel_idx;
                end
            end
            if (transfer) begin
                rr_ptr <= out_idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed self-checking bench for prio_encoder_rr: fixed/edge, round-robin/level
// and a non-power-of-two round-robin instance.
module tb_prio_encoder_rr;

    logic clk;

    logic       f_rst_n, f_ready, f_valid;
    logic [7:0] f_req, f_mask, f_pending;
    logic [2:0] f_idx;

    logic       r_rst_n, r_ready, r_valid;
    logic [7:0] r_req, r_mask, r_pending;
    logic [2:0] r_idx;

    logic       s_rst_n, s_ready, s_valid;
    logic [4:0] s_req, s_mask, s_pending;
    logic [2:0] s_idx;

    int checks;
    int errors;
    int hold_count;
    int rr8_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int rr5_alt[4] = '{4, 0, 4, 0};
    int rr5_seq[6] = '{4, 3, 2, 1, 0, 4};

    prio_encoder_rr #(.N(8), .MODE(0), .EDGE(1)) dut_fixed (
        .clk(clk), .rst_n(f_rst_n), .req_i(f_req), .mask_i(f_mask), .out_ready(f_ready),
        .out_valid(f_valid), .out_idx(f_idx), .pending_o(f_pending)
    );

    prio_encoder_rr #(.N(8), .MODE(1), .EDGE(0)) dut_rr (
        .clk(clk), .rst_n(r_rst_n), .req_i(r_req), .mask_i(r_mask), .out_ready(r_ready),
        .out_valid(r_valid), .out_idx(r_idx), .pending_o(r_pending)
    );

    prio_encoder_rr #(.N(5), .MODE(1), .EDGE(0)) dut_rr5 (
        .clk(clk), .rst_n(s_rst_n), .req_i(s_req), .mask_i(s_mask), .out_ready(s_ready),
        .out_valid(s_valid), .out_idx(s_idx), .pending_o(s_pending)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to just after the next rising edge; outputs are sampled and inputs driven here
    task automatic advance_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence across the three instances
    initial begin
        checks = 0;
        errors = 0;
        f_rst_n = 1'b0; f_req = '0; f_mask = 8'hFF; f_ready = 1'b1;
        r_rst_n = 1'b0; r_req = '0; r_mask = 8'hFF; r_ready = 1'b1;
        s_rst_n = 1'b0; s_req = '0; s_mask = 5'h1F; s_ready = 1'b1;
        advance_cycle();
        advance_cycle();

        // Reset state
        check_output("rst f valid",   32'(f_valid),   32'd0);
        check_output("rst f idx",     32'(f_idx),     32'd0);
        check_output("rst f pending", 32'(f_pending), 32'h00);
        check_output("rst r valid",   32'(r_valid),   32'd0);
        check_output("rst r pending", 32'(r_pending), 32'h00);
        check_output("rst s valid",   32'(s_valid),   32'd0);
        check_output("rst s pending", 32'(s_pending), 32'h00);
        f_rst_n = 1'b1; r_rst_n = 1'b1; s_rst_n = 1'b1;
        advance_cycle();

        // Fixed priority: single-cycle pulse 0x05 drains as 2 then 0
        f_req = 8'h05;
        advance_cycle();
        check_output("t1 pending set", 32'(f_pending), 32'h05);
        check_output("t1 valid early", 32'(f_valid),   32'd0);
        f_req = 8'h00;
        advance_cycle();
        check_output("t1 valid a", 32'(f_valid), 32'd1);
        check_output("t1 idx a",   32'(f_idx),   32'd2);
        advance_cycle();
        check_output("t1 valid b",   32'(f_valid),   32'd1);
        check_output("t1 idx b",     32'(f_idx),     32'd0);
        check_output("t1 pending b", 32'(f_pending), 32'h01);
        advance_cycle();
        check_output("t1 valid end",   32'(f_valid),   32'd0);
        check_output("t1 pending end", 32'(f_pending), 32'h00);

        // Stall: index 7 stays presented even when masked off mid-stall
        f_ready = 1'b0;
        f_req = 8'h81;
        advance_cycle();
        check_output("t2 pending", 32'(f_pending), 32'h81);
        f_req = 8'h00;
        advance_cycle();
        check_output("t2 valid", 32'(f_valid), 32'd1);
        check_output("t2 idx",   32'(f_idx),   32'd7);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) f_mask = 8'h7F;
            advance_cycle();
            check_output($sformatf("t2 hold valid[%0d]", i), 32'(f_valid), 32'd1);
            check_output($sformatf("t2 hold idx[%0d]", i),   32'(f_idx),   32'd7);
        end
        f_ready = 1'b1;
        advance_cycle();
        check_output("t2 after valid",   32'(f_valid),   32'd1);
        check_output("t2 after idx",     32'(f_idx),     32'd0);
        check_output("t2 after pending", 32'(f_pending), 32'h01);
        advance_cycle();
        check_output("t2 end valid",   32'(f_valid),   32'd0);
        check_output("t2 end pending", 32'(f_pending), 32'h00);
        f_mask = 8'hFF;

        // Edge capture: a long high level yields one transfer
        f_req = 8'h08;
        hold_count = 0;
        for (int i = 0; i < 10; i++) begin
            advance_cycle();
            if (f_valid) hold_count++;
        end
        check_output("t4 transfers", 32'(hold_count), 32'd1);
        check_output("t4 pending",   32'(f_pending),  32'h00);
        f_req = 8'h00;
        advance_cycle();
        f_ready = 1'b0;
        f_req = 8'h08;
        advance_cycle();
        f_req = 8'h00;
        advance_cycle();
        check_output("t4 present valid", 32'(f_valid), 32'd1);
        check_output("t4 present idx",   32'(f_idx),   32'd3);
        f_req = 8'h08;
        f_ready = 1'b1;
        advance_cycle();
        check_output("t4 repend valid",   32'(f_valid),   32'd0);
        check_output("t4 repend pending", 32'(f_pending), 32'h08);
        f_req = 8'h00;
        advance_cycle();
        check_output("t4 again valid", 32'(f_valid), 32'd1);
        check_output("t4 again idx",   32'(f_idx),   32'd3);
        advance_cycle();
        check_output("t4 final valid",   32'(f_valid),   32'd0);
        check_output("t4 final pending", 32'(f_pending), 32'h00);

        // Round-robin with all lines held high (level capture)
        r_req = 8'hFF;
        advance_cycle();
        check_output("t3 pending", 32'(r_pending), 32'hFF);
        check_output("t3 valid0",  32'(r_valid),   32'd0);
        advance_cycle();
        for (int i = 0; i < 9; i++) begin
            check_output($sformatf("t3 valid[%0d]", i), 32'(r_valid), 32'd1);
            check_output($sformatf("t3 idx[%0d]", i),   32'(r_idx),   32'(rr8_seq[i]));
            advance_cycle();
        end

        // Reset mid-operation, then round-robin restarts from bit 7
        r_req = 8'h00;
        r_rst_n = 1'b0;
        advance_cycle();
        r_rst_n = 1'b1;
        r_req = 8'h3C;
        advance_cycle();
        check_output("t5 pending", 32'(r_pending), 32'h3C);
        r_req = 8'h00;
        advance_cycle();
        check_output("t5 idx a", 32'(r_idx), 32'd5);
        advance_cycle();
        check_output("t5 idx b", 32'(r_idx), 32'd4);
        r_ready = 1'b0;
        r_req = 8'h3C;
        advance_cycle();
        check_output("t5 pre pending", 32'(r_pending), 32'h3C);
        check_output("t5 pre valid",   32'(r_valid),   32'd1);
        r_req = 8'h00;
        r_rst_n = 1'b0;
        advance_cycle();
        check_output("t5 rst valid",   32'(r_valid),   32'd0);
        check_output("t5 rst pending", 32'(r_pending), 32'h00);
        check_output("t5 rst idx",     32'(r_idx),     32'd0);
        r_rst_n = 1'b1;
        r_ready = 1'b1;
        r_req = 8'h81;
        advance_cycle();
        check_output("t5 post pending", 32'(r_pending), 32'h81);
        r_req = 8'h00;
        advance_cycle();
        check_output("t5 post valid a", 32'(r_valid), 32'd1);
        check_output("t5 post idx a",   32'(r_idx),   32'd7);
        advance_cycle();
        check_output("t5 post valid b", 32'(r_valid), 32'd1);
        check_output("t5 post idx b",   32'(r_idx),   32'd0);
        advance_cycle();
        check_output("t5 post idle", 32'(r_valid), 32'd0);

        // N=5 round-robin: alternating 4,0 then full wrap 4..0,4
        s_req = 5'h11;
        advance_cycle();
        check_output("t6 pending 11", 32'(s_pending), 32'h11);
        advance_cycle();
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("t6 alt valid[%0d]", i), 32'(s_valid), 32'd1);
            check_output($sformatf("t6 alt idx[%0d]", i),   32'(s_idx),   32'(rr5_alt[i]));
            advance_cycle();
        end
        s_req = 5'h00;
        s_rst_n = 1'b0;
        advance_cycle();
        s_rst_n = 1'b1;
        s_req = 5'h1F;
        advance_cycle();
        check_output("t6 pending 1f", 32'(s_pending), 32'h1F);
        advance_cycle();
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("t6 wrap valid[%0d]", i), 32'(s_valid), 32'd1);
            check_output($sformatf("t6 wrap idx[%0d]", i),   32'(s_idx),   32'(rr5_seq[i]));
            advance_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
